// File: rtl/pipe_hazard_arbiter.sv
// pipe_hazard_arbiter: priority hazard arbiter driving per-stage stall/flush
// for a NUM_STAGES pipeline, with deferred-flush latch and stall watchdog.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   req_i           - hazard request per source (index 0 = highest priority)
//   stall_mask_i    - stall vector of source k at [k*NUM_STAGES +: NUM_STAGES]
//   flush_mask_i    - flush vector of source k, same packing
//   defer_en_i      - source's flush is latched when it is not the winner
//   block_i         - source holds off application of a latched flush
//   stall_o/flush_o - per-stage stall and flush (bit 0 = PC)
//   win_o           - winning source index, 0 when idle
//   busy_o          - any request present
//   pend_o          - a deferred flush is latched
//   wd_fire_o       - one-cycle watchdog pulse
//   cnt_sel_i       - performance counter read select
//   cnt_clr_i       - synchronous clear of all performance counters
//   cnt_o           - selected counter, registered
//
// Optional macro PIPE_HAZARD_PERF_CNT_EN adds one saturating stall-cycle
// counter per source; without it cnt_o is tied to zero.

module pipe_hazard_arbiter #(
    parameter int NUM_STAGES = 6,
    parameter int NUM_REQ    = 8,
    parameter int WD_LIMIT   = 1024,
    parameter int CNT_W      = 32,
    localparam int WIN_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*NUM_STAGES-1:0] stall_mask_i,
    input  logic [NUM_REQ*NUM_STAGES-1:0] flush_mask_i,
    input  logic [NUM_REQ-1:0]            defer_en_i,
    input  logic [NUM_REQ-1:0]            block_i,
    output logic [NUM_STAGES-1:0]         stall_o,
    output logic [NUM_STAGES-1:0]         flush_o,
    output logic [WIN_W-1:0]              win_o,
    output logic                          busy_o,
    output logic                          pend_o,
    output logic                          wd_fire_o,
    input  logic [WIN_W-1:0]              cnt_sel_i,
    input  logic                          cnt_clr_i,
    output logic [CNT_W-1:0]              cnt_o
);

    localparam int WD_W = $clog2(WD_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);
    localparam logic [WD_W-1:0] WD_SAT  = WD_W'(WD_LIMIT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PEND = 2'd2;
    localparam logic [1:0] S_WDOG = 2'd3;

    logic                  w_any;
    logic                  w_blocked;
    logic                  w_pend_apply;
    logic                  w_wd_force;
    logic                  w_wd_trig;
    logic [WIN_W-1:0]      w_win;
    logic [NUM_STAGES-1:0] w_win_stall;
    logic [NUM_STAGES-1:0] w_win_flush;
    logic [NUM_STAGES-1:0] w_defer;
    logic [NUM_STAGES-1:0] w_pend_part;
    logic [NUM_STAGES-1:0] w_stall;
    logic [NUM_STAGES-1:0] w_flush;
    logic [NUM_STAGES-1:0] w_pend_n;
    logic [1:0]            w_state_n;
    logic [WD_W-1:0]       w_wd_cnt_n;

    logic [NUM_STAGES-1:0] r_pend;
    logic [WD_W-1:0]       r_wd_cnt;
    logic [1:0]            r_state;

    // ------------------------------------------------------------------
    // Priority select: scanning downward leaves the lowest set index.
    // ------------------------------------------------------------------
    always_comb begin
        w_win       = '0;
        w_win_stall = '0;
        w_win_flush = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                w_win       = WIN_W'(k);
                w_win_stall = stall_mask_i[k*NUM_STAGES +: NUM_STAGES];
                w_win_flush = flush_mask_i[k*NUM_STAGES +: NUM_STAGES];
            end
        end
    end

    // Flushes of deferrable losers; the winner applies its own directly.
    always_comb begin
        w_defer = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_i[k] && defer_en_i[k] && (WIN_W'(k) != w_win)) begin
                w_defer = w_defer
                        | flush_mask_i[k*NUM_STAGES +: NUM_STAGES];
            end
        end
    end

    assign w_any        = |req_i;
    assign w_blocked    = |(req_i & block_i);
    assign w_pend_apply = (r_pend != '0) && !w_blocked;
    assign w_pend_part  = w_pend_apply ? r_pend : '0;

    // The WDOG state itself is the one-cycle force flag.
    assign w_wd_force = (r_state == S_WDOG);

    always_comb begin
        w_stall = '0;
        w_flush = w_pend_part;
        if (w_any) begin
            w_stall = w_win_stall;
            w_flush = w_win_flush | w_pend_part;
        end
        if (w_wd_force) begin
            w_stall = '0;
            w_flush = '1;
        end
    end

    // Outputs are forced to the safe state for as long as reset is held.
    always_comb begin
        stall_o = w_stall;
        flush_o = w_flush;
        win_o   = w_win;
        if (rst) begin
            stall_o = '0;
            flush_o = '1;
            win_o   = '0;
        end
    end

    assign busy_o    = w_any;
    assign pend_o    = (r_pend != '0);
    assign wd_fire_o = w_wd_force;

    // ------------------------------------------------------------------
    // Deferred flush latch. A capture in an apply cycle is kept.
    // ------------------------------------------------------------------
    assign w_pend_n = (w_pend_apply ? '0 : r_pend) | w_defer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_n;
        end
    end

    // ------------------------------------------------------------------
    // Watchdog: consecutive PC-stall cycles, saturating.
    // ------------------------------------------------------------------
    assign w_wd_trig = w_stall[0] && (r_wd_cnt == WD_LAST);

    always_comb begin
        w_wd_cnt_n = '0;
        if (w_stall[0]) begin
            w_wd_cnt_n = (r_wd_cnt == WD_SAT) ? r_wd_cnt
                                              : r_wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= w_wd_cnt_n;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n = r_state;
        if (w_wd_trig) begin
            w_state_n = S_WDOG;
        end else begin
            case (r_state)
                S_WDOG: w_state_n = S_IDLE;
                S_IDLE, S_RUN, S_PEND: begin
                    if (w_any) begin
                        w_state_n = S_RUN;
                    end else if (w_pend_n != '0) begin
                        w_state_n = S_PEND;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // ------------------------------------------------------------------
    // Per-source stall-cycle counters.
    // ------------------------------------------------------------------
`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_cnt [NUM_REQ];
    logic [CNT_W-1:0] r_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                r_cnt[k] <= '0;
            end
            r_cnt_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (cnt_clr_i) begin
                    r_cnt[k] <= '0;
                end else if (w_any && (w_win == WIN_W'(k))
                        && (stall_mask_i[k*NUM_STAGES +: NUM_STAGES] != '0)
                        && (r_cnt[k] != '1)) begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
            r_cnt_q <= r_cnt[cnt_sel_i];
        end
    end

    assign cnt_o = r_cnt_q;
`else
    logic w_unused_cnt;

    assign w_unused_cnt = ^{cnt_sel_i, cnt_clr_i};
    assign cnt_o        = '0;
`endif

endmodule

// File: doc/pipe_hazard_arbiter.md
Name: pipe_hazard_arbiter

Overview:
- Parametrised successor to the 6-stage stall/flush controller.
- Arbitrates NUM_REQ hazard sources, highest priority first, and drives per-stage stall and flush vectors for a NUM_STAGES pipeline.
- Stall and flush masks for each source are run-time inputs, normally tied off at integration.
- Adds sequential behaviour:
  - deferred-flush latch: a redirect that arrives while a blocking source (e.g. an in-flight fetch) is active is held, not lost;
  - stall watchdog;
  - optional per-source stall-cycle counters.

Parameters:
- NUM_STAGES, 6: stage count. Bit 0 = PC, highest bit = MEM_WB.
- NUM_REQ, 8: number of hazard sources. Index 0 = highest priority.
- WD_LIMIT, 1024: consecutive PC-stall cycles before the watchdog fires. Must be ≥ 2.
- CNT_W, 32: width of each performance counter (optional feature only).

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- req_i, input, NUM_REQ: hazard request per source.
- stall_mask_i, input, NUM_REQ*NUM_STAGES: stall vector of source k at [k*NUM_STAGES +: NUM_STAGES].
- flush_mask_i, input, NUM_REQ*NUM_STAGES: flush vector of source k, same packing.
- defer_en_i, input, NUM_REQ: source's flush may be deferred when it is not the winner.
- block_i, input, NUM_REQ: source blocks application of a deferred flush.
- stall_o, output, NUM_STAGES: per-stage stall.
- flush_o, output, NUM_STAGES: per-stage flush.
- win_o, output, $clog2(NUM_REQ): index of the winning source. 0 when idle.
- busy_o, output, 1: any req_i bit set.
- pend_o, output, 1: a deferred flush is pending.
- wd_fire_o, output, 1: watchdog pulse, one cycle.
- cnt_sel_i, input, $clog2(NUM_REQ): counter read select.
- cnt_clr_i, input, 1: synchronous clear of all counters.
- cnt_o, output, CNT_W: selected counter value.

Behaviour:
- Arbitration (combinational):
  - winner w = lowest set index of req_i.
  - No request: stall_o = 0 and flush_o = pend_apply ? pend_q : 0.
- With a winner w:
  - stall_o = stall_mask[w] & ~wd_force.
  - flush_o = flush_mask[w] | (pend_apply ? pend_q : 0) | (wd_force ? all-ones : 0).
- Deferred flush register pend_q [NUM_STAGES], reset 0:
  - pend_apply = (pend_q != 0) & ~|(req_i & block_i).
  - Next value: pend_q_n = (pend_apply ? 0 : pend_q) | OR over k ≠ w of (req_i[k] & defer_en_i[k] ? flush_mask[k] : 0).
  - A defer captured in the same cycle as an apply survives into the next cycle.
  - pend_o = (pend_q != 0).
- Watchdog:
  - wd_cnt counts consecutive cycles with stall_o[0] = 1 and saturates at WD_LIMIT.
  - It clears on any cycle with stall_o[0] = 0.
  - When wd_cnt == WD_LIMIT-1 and stall_o[0] = 1, the next cycle asserts wd_force for exactly one cycle.
  - In that cycle: flush_o all-ones, stall_o = 0, wd_fire_o = 1, wd_cnt → 0.
- FSM (state register, reset IDLE):
  - IDLE: busy_o = 0. Any req → RUN. pend only → PEND.
  - RUN: a winner is active. No req and pend_q = 0 → IDLE. No req and pend_q ≠ 0 → PEND.
  - PEND: pend_q ≠ 0 and blocked. Unblocked → IDLE, or RUN if req is present.
  - WDOG: one cycle, entered on wd_force, always exits to IDLE.
  - The state is observable only through busy_o, pend_o and wd_fire_o.
- Reset:
  - While rst = 1: stall_o = 0, flush_o = all-ones, win_o = 0, pend_q = 0, wd_cnt = 0, wd_fire_o = 0, counters = 0, state = IDLE.
  - Async assertion mid-stall aborts everything immediately. No deferred flush survives reset.
- Simultaneous events:
  - A source that is both winner and defer_en applies its flush directly and is never deferred.
  - Watchdog force has precedence over all masks.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_CNT_EN.
- Defined:
  - One CNT_W saturating counter per source. Counter k increments every cycle in which k is the winner and stall_mask[k] ≠ 0.
  - cnt_clr_i zeroes all counters and takes precedence over increment.
  - cnt_o = counter[cnt_sel_i], registered, 1-cycle read latency.
- Undefined: no counters are instantiated and cnt_o = 0 constantly.

Test Plan (NUM_STAGES=6, NUM_REQ=8; mask0 = stall 011111 / flush 100000; mask1 = stall 011101 / flush 000010 with block_i[1]=1; mask3 = stall 000010 / flush 001110 with defer_en_i[3]=1):
- req_i=00001001 for one cycle -> stall_o=011111, flush_o=100000, win_o=0, pend_o=1 next cycle. Then req_i=0 -> flush_o=001110 for one cycle, pend_o=0.
- req_i=00001010 for 3 cycles, then 00000010 for 2 cycles, then 0 -> pend held throughout, stall_o=011101 while blocked. First cycle with req[1]=0 gives flush_o=001110.
- req_i=00000001 held with WD_LIMIT=4 -> stall_o[0]=1 for 4 cycles. 5th cycle: wd_fire_o=1, flush_o=111111, stall_o=0. Then the count restarts.
- Assert rst asynchronously mid-stall with pend_q=001110 -> immediately stall_o=0, flush_o=111111. After release with req_i=0: flush_o=000000, pend_o=0.
- req_i=10000000 (only lowest priority) -> win_o=7 and stall_o/flush_o equal mask7. Adding req_i[2] -> win_o=2 in the same cycle.
- PERF_CNT_EN: 10 stall cycles from source 1, cnt_sel_i=1 -> cnt_o=10 one cycle later. cnt_clr_i for one cycle -> cnt_o=0. Counters saturate at 2^CNT_W-1 (test with CNT_W=4: 20 cycles -> 15).
